vend_dpu: RTL
=============

VEND_DPU -- requirements
Module: vend_dpu

Interface
REQ-001 The block SHALL have parameter CW, default 8, meaning credit/price/coin width in bits.
REQ-002 The block SHALL have parameter NSEL, default 2, meaning item-select width (2**NSEL price entries).
REQ-003 The block SHALL have parameter MAXCREDIT, default 200, meaning maximum credit held.
REQ-004 The block SHALL have parameter CHANGE_UNIT, default 10, meaning value returned per change pulse.
REQ-005 The block SHALL have port clk  in  1  the single clock; all state changes on rising edge.
REQ-006 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port coin_valid  in  1  a coin is presented this cycle.
REQ-008 The block SHALL have port coin_val  in  CW  the value of the presented coin.
REQ-009 The block SHALL have port sel_valid  in  1  an item selection is presented this cycle.
REQ-010 The block SHALL have port sel  in  NSEL  the selected item index.
REQ-011 The block SHALL have port cancel  in  1  refund request (see Configuration).
REQ-012 The block SHALL have ports prog_we  in  1, prog_addr  in  NSEL, prog_data  in  CW, forming the price-table write port.
REQ-013 The block SHALL have port credit  out  CW  the current credit register.
REQ-014 The block SHALL have ports vend_pulse  out  1 and vend_item  out  NSEL, carrying the dispense strobe and the item dispensed.
REQ-015 The block SHALL have ports chg_pulse  out  1 and coin_reject  out  1, carrying one change unit and the coin-bounced strobe.
REQ-016 The block SHALL have ports err_insuff  out  1 and busy  out  1, carrying the insufficient-credit strobe and state!=IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, VEND and CHANGE; busy SHALL be high in VEND and CHANGE.
REQ-018 The price table SHALL be 2**NSEL x CW registers; prog_we SHALL write prog_data to prog_addr at the edge in any state, with the new price used from the next selection.
REQ-019 In IDLE, a coin with credit+coin_val <= MAXCREDIT (computed at CW+1 bits) SHALL be added to credit at the edge.
REQ-020 A coin causing overflow, or arriving while busy, SHALL leave credit unchanged and pulse coin_reject high for exactly one cycle after the edge.
REQ-021 In IDLE, when sel_valid is high and credit >= price[sel], the block SHALL subtract the price, latch vend_item=sel and enter VEND; a price of 0 SHALL vend free.
REQ-022 In IDLE, when sel_valid is high and credit < price[sel], the block SHALL pulse err_insuff for one cycle, leave credit unchanged and stay in IDLE.
REQ-023 When sel_valid and coin_valid occur together in IDLE, the selection SHALL take priority and the coin SHALL be rejected per REQ-020.
REQ-024 VEND SHALL last exactly one cycle with vend_pulse=1, then go to CHANGE if credit >= CHANGE_UNIT, else to IDLE.
REQ-025 In CHANGE, each edge with credit >= CHANGE_UNIT SHALL subtract CHANGE_UNIT and assert chg_pulse for the following cycle.
REQ-026 CHANGE SHALL go to IDLE at the edge where credit < CHANGE_UNIT; any residual below CHANGE_UNIT SHALL remain as credit.
REQ-027 sel_valid SHALL be ignored while busy, with no err_insuff.
REQ-028 All outputs SHALL be registered; latency from a sel edge to vend_pulse SHALL be 1 cycle.

Reset
REQ-029 When rst is high at an edge, the block SHALL set state=IDLE, credit=0, vend_item=0 and all pulse outputs and busy to 0, including mid-VEND or mid-CHANGE.
REQ-030 On reset the price table SHALL clear to 0.
REQ-031 rst SHALL take priority over every other input.

Configuration
REQ-032 With VEND_DPU_REFUND_EN defined, cancel high in IDLE SHALL enter CHANGE and refund credit per REQ-025/026, and cancel SHALL win over a simultaneous sel_valid or coin_valid (the coin is rejected).
REQ-033 With VEND_DPU_REFUND_EN undefined, cancel SHALL be ignored and no refund logic SHALL be synthesised.

Verification (CW=8, NSEL=2, MAXCREDIT=200, CHANGE_UNIT=10, price[1]=50)
REQ-034 Coins 20,20,20 then sel=1 -> credit 60, vend_pulse for 1 cycle with vend_item=1, credit 10, one chg_pulse, credit 0, IDLE.
REQ-035 Credit 30, sel=1 -> err_insuff for 1 cycle, credit 30, no vend_pulse; credit 190 plus coin 20 -> coin_reject, credit 190.
REQ-036 Coin 10 together with sel=1 at credit 50 -> vend, coin_reject, final credit 0.
REQ-037 REFUND_EN, credit 35, cancel -> 3 chg_pulses on consecutive cycles, credit 5, IDLE; coin during CHANGE -> coin_reject.
REQ-038 rst asserted on the 2nd chg_pulse cycle -> next cycle credit 0, busy 0, prices 0; prog write price[2]=30 then sel=2 at credit 30 -> vend, credit 0.

Source files
------------

// File: rtl/vend_dpu.sv
// Vending-machine datapath/control: coin accumulation, programmable price table,
// single-cycle vend strobe and change payout. Optional refund-on-cancel via VEND_DPU_REFUND_EN.
module vend_dpu #(
   parameter int CW          = 8,
   parameter int NSEL        = 2,
   parameter int MAXCREDIT   = 200,
   parameter int CHANGE_UNIT = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            coin_valid,
   input  logic [CW-1:0]   coin_val,
   input  logic            sel_valid,
   input  logic [NSEL-1:0] sel,
   input  logic            cancel,
   input  logic            prog_we,
   input  logic [NSEL-1:0] prog_addr,
   input  logic [CW-1:0]   prog_data,
   output logic [CW-1:0]   credit,
   output logic            vend_pulse,
   output logic [NSEL-1:0] vend_item,
   output logic            chg_pulse,
   output logic            coin_reject,
   output logic            err_insuff,
   output logic            busy
);

   localparam int NPRICE = 2 ** NSEL;
   localparam logic [CW:0]   MAX_C = (CW + 1)'(MAXCREDIT);
   localparam logic [CW-1:0] CU_C  = CW'(CHANGE_UNIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } state_t;

   state_t          state_reg;
   logic [CW-1:0]   credit_reg;
   logic [NSEL-1:0] vend_item_reg;
   logic            vend_pulse_reg;
   logic            chg_pulse_reg;
   logic            coin_reject_reg;
   logic            err_insuff_reg;
   logic            busy_reg;

   logic [CW-1:0]   price_tbl [NPRICE];
   logic [CW-1:0]   sel_price;
   logic [CW:0]     coin_sum;
   logic            cancel_req;

   // Each price entry is its own register so the whole table clears on reset.
   genvar gi;
   generate
      for (gi = 0; gi < NPRICE; gi++) begin : g_price
         logic [CW-1:0] price_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               price_reg <= '0;
            end else if (prog_we && (prog_addr == NSEL'(gi))) begin
               price_reg <= prog_data;
            end
         end
         assign price_tbl[gi] = price_reg;
      end
   endgenerate

`ifdef VEND_DPU_REFUND_EN
   assign cancel_req = cancel;
`else
   logic unused_cancel;
   assign unused_cancel = cancel;
   assign cancel_req    = 1'b0;
`endif

   assign sel_price = price_tbl[sel];
   assign coin_sum  = {1'b0, credit_reg} + {1'b0, coin_val};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         credit_reg      <= '0;
         vend_item_reg   <= '0;
         vend_pulse_reg  <= 1'b0;
         chg_pulse_reg   <= 1'b0;
         coin_reject_reg <= 1'b0;
         err_insuff_reg  <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         vend_pulse_reg  <= 1'b0;
         chg_pulse_reg   <= 1'b0;
         coin_reject_reg <= 1'b0;
         err_insuff_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               // Priority: cancel, then selection, then coin; a coin losing arbitration bounces.
               if (cancel_req) begin
                  coin_reject_reg <= coin_valid;
                  state_reg       <= CHANGE;
                  busy_reg        <= 1'b1;
               end else if (sel_valid) begin
                  coin_reject_reg <= coin_valid;
                  if (credit_reg >= sel_price) begin
                     credit_reg     <= credit_reg - sel_price;
                     vend_item_reg  <= sel;
                     vend_pulse_reg <= 1'b1;
                     state_reg      <= VEND;
                     busy_reg       <= 1'b1;
                  end else begin
                     err_insuff_reg <= 1'b1;
                  end
               end else if (coin_valid) begin
                  if (coin_sum <= MAX_C) begin
                     credit_reg <= coin_sum[CW-1:0];
                  end else begin
                     coin_reject_reg <= 1'b1;
                  end
               end
            end
            VEND: begin
               coin_reject_reg <= coin_valid;
               if (credit_reg >= CU_C) begin
                  state_reg <= CHANGE;
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            CHANGE: begin
               coin_reject_reg <= coin_valid;
               if (credit_reg >= CU_C) begin
                  credit_reg    <= credit_reg - CU_C;
                  chg_pulse_reg <= 1'b1;
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign credit      = credit_reg;
   assign vend_item   = vend_item_reg;
   assign vend_pulse  = vend_pulse_reg;
   assign chg_pulse   = chg_pulse_reg;
   assign coin_reject = coin_reject_reg;
   assign err_insuff  = err_insuff_reg;
   assign busy        = busy_reg;

endmodule
